// File: rtl/huff_pkg.sv
// Types and helpers shared by the Huffman decoder and its companion encoder.
package huff_pkg;

  localparam int MAX_CHAR_COUNT = 3;
  // Upper bound on code width. Table entries are stored zero-extended to this width.
  localparam int CODE_W_MAX     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    ERROR = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0]            ch;
    logic [CODE_W_MAX-1:0] code;
    logic [CODE_W_MAX-1:0] mask;
  } tbl_entry_t;

  function automatic logic [7:0] popcount(input logic [CODE_W_MAX-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < CODE_W_MAX; i++) n = n + {7'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/huff_code_match.sv
// Combinational lookup of the partial code against every table entry.
// The lowest-index entry wins when several entries match.
module huff_code_match #(
  parameter int N      = 3,
  parameter int CODE_W = 3,
  parameter int LEN_W  = 2,
  parameter int IDX_W  = 2
) (
  input  huff_pkg::tbl_entry_t [N-1:0] tbl,
  input  logic [CODE_W-1:0]            next_acc,
  input  logic [LEN_W-1:0]             next_len,
  output logic                         hit,
  output logic [IDX_W-1:0]             idx
);
  import huff_pkg::*;

  logic [CODE_W_MAX-1:0] acc_ext;
  logic [7:0]            len_ext;
  logic                  unused_ch;

  // Scan from the top entry down so the lowest matching index is the last one written.
  always_comb begin
    acc_ext              = '0;
    acc_ext[CODE_W-1:0]  = next_acc;
    len_ext              = 8'(next_len);
    hit                  = 1'b0;
    idx                  = '0;
    unused_ch            = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      // Character bytes do not take part in matching.
      unused_ch = unused_ch ^ (^tbl[i].ch);
      if ((popcount(tbl[i].mask) == len_ext) &&
          ((tbl[i].code & tbl[i].mask) == acc_ext)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/huff_decoder.sv
// Serial Huffman decoder: shifts code bits in MSB-first, looks up the
// loaded code table after each bit, and hands decoded characters out
// through a valid/ready pair. An unmatched full-width code sets a sticky
// error that only a table reload clears.
//
// state | meaning
// IDLE  | no table loaded since reset
// RUN   | accepting code bits
// HOLD  | character presented, waiting for char_ready
// ERROR | invalid code seen, waiting for tbl_load
module huff_decoder #(
  parameter int MAX_CHAR_COUNT = huff_pkg::MAX_CHAR_COUNT,
  parameter int CODE_W         = MAX_CHAR_COUNT
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  tbl_load,
  input  logic [MAX_CHAR_COUNT-1:0][7:0]        tbl_char,
  input  logic [MAX_CHAR_COUNT-1:0][CODE_W-1:0] tbl_code,
  input  logic [MAX_CHAR_COUNT-1:0][CODE_W-1:0] tbl_mask,
  input  logic                                  bit_valid,
  input  logic                                  bit_in,
  output logic                                  bit_ready,
  output logic                                  char_valid,
  output logic [7:0]                            char_out,
  input  logic                                  char_ready,
  output logic                                  err
);
  import huff_pkg::*;

  localparam int LEN_W = $clog2(CODE_W + 1);
  localparam int IDX_W = (MAX_CHAR_COUNT > 1) ? $clog2(MAX_CHAR_COUNT) : 1;

  state_t                              state_q, state_d;
  logic [CODE_W-1:0]                   acc_q, acc_d;
  logic [LEN_W-1:0]                    len_q, len_d;
  logic [7:0]                          char_q, char_d;
  logic                                cv_q, cv_d;
  logic                                err_q, err_d;
  tbl_entry_t [MAX_CHAR_COUNT-1:0]     tbl_q, tbl_d;

  logic [CODE_W-1:0]                   acc_nxt;
  logic [LEN_W-1:0]                    len_nxt;
  logic                                hit;
  logic [IDX_W-1:0]                    hit_idx;

  assign bit_ready  = (state_q == RUN);
  assign char_valid = cv_q;
  assign char_out   = char_q;
  assign err        = err_q;

  assign acc_nxt = {acc_q[CODE_W-2:0], bit_in};
  assign len_nxt = len_q + LEN_W'(1);

  huff_code_match #(
    .N      (MAX_CHAR_COUNT),
    .CODE_W (CODE_W),
    .LEN_W  (LEN_W),
    .IDX_W  (IDX_W)
  ) u_match (
    .tbl      (tbl_q),
    .next_acc (acc_nxt),
    .next_len (len_nxt),
    .hit      (hit),
    .idx      (hit_idx)
  );

  // State register and datapath flops; reset empties the table so decoding needs a reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      len_q   <= '0;
      char_q  <= '0;
      cv_q    <= 1'b0;
      err_q   <= 1'b0;
      tbl_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      char_q  <= char_d;
      cv_q    <= cv_d;
      err_q   <= err_d;
      tbl_q   <= tbl_d;
    end
  end

  // Next-state logic; a table load overrides everything, including a bit handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    len_d   = len_q;
    char_d  = char_q;
    cv_d    = cv_q;
    err_d   = err_q;
    tbl_d   = tbl_q;

    if (tbl_load) begin
      for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
        tbl_d[i]                   = '0;
        tbl_d[i].ch                = tbl_char[i];
        tbl_d[i].code[CODE_W-1:0]  = tbl_code[i];
        tbl_d[i].mask[CODE_W-1:0]  = tbl_mask[i];
      end
      acc_d   = '0;
      len_d   = '0;
      cv_d    = 1'b0;
      err_d   = 1'b0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (bit_valid) begin
            if (hit) begin
              char_d  = tbl_q[hit_idx].ch;
              cv_d    = 1'b1;
              acc_d   = '0;
              len_d   = '0;
              state_d = HOLD;
            end else if (len_nxt == LEN_W'(CODE_W)) begin
              err_d   = 1'b1;
              acc_d   = '0;
              len_d   = '0;
              state_d = ERROR;
            end else begin
              acc_d   = acc_nxt;
              len_d   = len_nxt;
            end
          end
        end
        HOLD: begin
          if (char_ready) begin
            cv_d    = 1'b0;
            state_d = RUN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/huff_decoder.md
HUFF_DECODER -- requirements
Module: huff_decoder

Interface
REQ-001 The block SHALL have parameter MAX_CHAR_COUNT, default 3, giving the number of code-table entries.
REQ-002 The block SHALL have parameter CODE_W, default MAX_CHAR_COUNT, giving the maximum code length in bits.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tbl_load  input  1  one-cycle pulse; capture code table.
REQ-006 tbl_char  input  MAX_CHAR_COUNT x 8  character per entry.
REQ-007 tbl_code  input  MAX_CHAR_COUNT x CODE_W  code per entry, right-aligned; first-transmitted bit is MSB of the valid field.
REQ-008 tbl_mask  input  MAX_CHAR_COUNT x CODE_W  contiguous low-order ones; popcount is code length; zero means the entry is unused.
REQ-009 bit_valid  input  1  serial code bit present.
REQ-010 bit_in  input  1  serial code bit.
REQ-011 bit_ready  output  1  decoder accepts a bit this cycle.
REQ-012 char_valid  output  1  decoded character present.
REQ-013 char_out  output  8  decoded character.
REQ-014 char_ready  input  1  sink accepts a character.
REQ-015 err  output  1  sticky invalid-code flag.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, HOLD and ERROR.
REQ-017 Transitions SHALL be: IDLE->RUN on tbl_load; RUN->HOLD on match; RUN->ERROR on no match at CODE_W bits; HOLD->RUN on char_ready; ERROR->RUN on tbl_load.
REQ-018 tbl_load in any state SHALL register the table, clear the accumulator and length counter, clear err and char_valid, and enter RUN on the next edge.
REQ-019 tbl_load SHALL win over a coincident bit handshake; that bit is discarded.
REQ-020 bit_ready SHALL equal (state==RUN) and SHALL be combinational from state only.
REQ-021 A bit SHALL be accepted when bit_valid and bit_ready are both high.
REQ-022 On acceptance: next_acc = {acc[CODE_W-2:0], bit_in}; next_len = len+1.
REQ-023 An entry SHALL match when its mask popcount equals next_len and (tbl_code & tbl_mask) equals next_acc.
REQ-024 On multiple matches, the lowest index SHALL win.
REQ-025 On a match: char_out <= entry char, char_valid <= 1, acc/len cleared, enter HOLD; char_valid is therefore high on the cycle after the last code bit is accepted.
REQ-026 On no match with next_len == CODE_W: err <= 1, enter ERROR, acc/len cleared, char_valid stays 0.
REQ-027 On no match with next_len < CODE_W: store acc/len, remain in RUN.
REQ-028 In HOLD, char_out and char_valid SHALL be stable until char_ready is high; char_valid then drops on the next edge.
REQ-029 len SHALL be $clog2(CODE_W+1) bits wide and SHALL never exceed CODE_W; acc SHALL be CODE_W bits.
REQ-030 With no bit_valid, the decoder SHALL hold state indefinitely with no timeout.

Reset
REQ-031 On reset: state=IDLE, char_valid=0, char_out=0, err=0, bit_ready=0, acc=0, len=0, table cleared (all masks 0).
REQ-032 Reset mid-code or mid-HOLD SHALL discard the partial code and any pending character, and a tbl_load is required before further decoding.
REQ-033 Reset SHALL take priority over tbl_load.

Structure
REQ-034 Package huff_pkg SHALL hold MAX_CHAR_COUNT, the state enum, and the table-entry typedef (char, code, mask); it is shared with the encoder.
REQ-035 Sub-module huff_code_match SHALL be combinational, taking table, next_acc and next_len, and returning hit and index.

Verification
REQ-036 Table a=0x61 code 10 mask 11, b=0x62 code 11 mask 11, c=0x63 code 0 mask 01; bits 1,0,0,1,1 with char_ready=1 -> chars 0x61, 0x63, 0x62, each char_valid one cycle after its last bit.
REQ-037 Same table; char_ready held low 3 cycles after 'c' -> char_out=0x63 stable, bit_ready=0, next bits wait; after release 'b' decodes, nothing lost.
REQ-038 Table x code 00, y code 01, z code 10, all mask 11, CODE_W=3; bits 1,1,0 -> err=1 after third bit, bit_ready=0; tbl_load -> err=0, RUN.
REQ-039 After a '1' bit is accepted, assert reset -> all outputs 0, IDLE; reload the REQ-036 table and send bit 0 -> 0x63.
REQ-040 tbl_load coincident with an accepted bit '1', then bits 0 -> 0x63 (the coincident bit is dropped).
REQ-041 Entries 0 and 2 both code 0 mask 01, chars 0x41 and 0x42; bit 0 -> 0x41.
